// File: rtl/ahb_regbank_slave.sv
// AHB-Lite register bank slave with NUM_REGS registers; register 0 reads back status_in.
// Each transfer can have optional wait states; illegal transfers get a two-cycle ERROR response.
module ahb_regbank_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  localparam int AW = $clog2(NUM_REGS) + $clog2(DATA_WIDTH / 8)
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic                           hsel,
  input  logic                           hready,
  input  logic [1:0]                     htrans,
  input  logic                           hwrite,
  input  logic [AW-1:0]                  haddr,
  input  logic [2:0]                     hsize,
  input  logic [DATA_WIDTH-1:0]          hwdata,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [DATA_WIDTH-1:0]          hrdata,
  output logic                           hreadyout,
  output logic                           hresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(NUM_REGS);
  localparam int BW    = $clog2(BYTES);
  localparam int OW    = (BW > 0) ? BW : 1;

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, ERR1, ERR2} state_t;

  state_t                state_q;
  logic [1:0]            waitCnt_q;
  logic                  write_q;
  logic [IW-1:0]         idx_q;
  logic [OW-1:0]         off_q;
  logic [2:0]            size_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wrPulse_q;

  logic                  phaseValid;
  logic                  phaseErr;
  logic [IW-1:0]         addrIdx;
  logic [OW-1:0]         addrOff;
  logic [7:0]            sizeBytes;
  logic [BYTES-1:0]      laneEn;
  logic                  commit;

  assign phaseValid = hsel && hready && (htrans == 2'b10 || htrans == 2'b11);
  assign addrIdx    = IW'(haddr >> BW);
  assign addrOff    = OW'(haddr % AW'(BYTES));
  assign sizeBytes  = 8'd1 << hsize;

  // Oversized, misaligned and status-register writes are all rejected.
  assign phaseErr = (sizeBytes > 8'(BYTES))
                 || ((8'(addrOff) & (sizeBytes - 8'd1)) != 8'd0)
                 || (hwrite && addrIdx == '0);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (waitCnt_q == 2'd0) begin
            state_q     <= ACCESS;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end else begin
            waitCnt_q <= waitCnt_q - 2'd1;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        // IDLE, ACCESS and ERR2 all accept a new address phase.
        default: begin
          if (phaseValid) begin
            write_q <= hwrite;
            idx_q   <= addrIdx;
            off_q   <= addrOff;
            size_q  <= hsize;
            if (phaseErr) begin
              state_q     <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_q     <= ACCESS;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= WAIT;
              waitCnt_q   <= 2'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    laneEn = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(off_q) && b < int'(off_q) + (1 << size_q)) begin
        laneEn[b] = 1'b1;
      end
    end
  end

  assign commit = (state_q == ACCESS) && write_q && (idx_q != '0);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wrPulse_q <= '0;
    end else begin
      wrPulse_q <= '0;
      if (commit) begin
        for (int b = 0; b < BYTES; b++) begin
          if (laneEn[b]) begin
            regs_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
          end
        end
        wrPulse_q[idx_q] <= 1'b1;
      end
    end
  end

  // Read data is combinational so a read right behind a write sees the fresh value.
  assign hrdata = (state_q == ACCESS && !write_q)
                ? ((idx_q == '0) ? status_in : regs_q[idx_q])
                : '0;

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign wr_pulse  = wrPulse_q;

endmodule

// File: doc/ahb_regbank_slave.md
AHB_REGBANK_SLAVE -- requirements
Module: ahb_regbank_slave

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32: bus and register width in bits; legal values 8, 16, 32.
- REQ-002 SHALL have parameter NUM_REGS, default 8: register count; power of 2, range 2..16; register 0 is read-only status.
- REQ-003 SHALL have parameter WAIT_STATES, default 0: wait cycles inserted per transfer; range 0..3.
- REQ-004 SHALL derive the local constant AW = log2(NUM_REGS) + log2(DATA_WIDTH/8), the byte address width.
- REQ-005 hclk  in  1  sole clock; all state updates on its rising edge.
- REQ-006 hreset  in  1  asynchronous, active-high reset.
- REQ-007 hsel  in  1  slave select.
- REQ-008 hready  in  1  bus ready; an address phase is sampled only when hready=1.
- REQ-009 htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- REQ-010 hwrite  in  1  1 = write, 0 = read.
- REQ-011 haddr  in  AW  byte address.
- REQ-012 hsize  in  3  transfer size; bytes = 2^hsize.
- REQ-013 hwdata  in  DATA_WIDTH  write data; valid in the data phase.
- REQ-014 status_in  in  DATA_WIDTH  value returned on reads of register 0.
- REQ-015 hrdata  out  DATA_WIDTH  read data.
- REQ-016 hreadyout  out  1  data phase complete.
- REQ-017 hresp  out  1  0 = OKAY, 1 = ERROR.
- REQ-018 reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; the slice for register 0 is always 0.
- REQ-019 wr_pulse  out  NUM_REGS  one-cycle strobe for each register written.

Function
- REQ-020 SHALL treat an address phase as valid when hsel=1, hready=1 and htrans[1]=1 (NONSEQ or SEQ); on a valid phase it latches hwrite, haddr and hsize.
- REQ-021 SHALL treat IDLE, BUSY or an unselected cycle as no transfer: next state IDLE, OKAY response, hreadyout=1.
- REQ-022 SHALL flag a valid address phase as an error when any of these holds:
  - 2^hsize exceeds DATA_WIDTH/8;
  - haddr is not aligned to 2^hsize;
  - the transfer writes register 0.
- REQ-023 SHALL use an FSM with states IDLE, WAIT, ACCESS, ERR1 and ERR2.
- REQ-024 IDLE: hreadyout=1, hresp=0.
- REQ-025 IDLE transitions on a valid phase:
  - error flagged -> ERR1;
  - WAIT_STATES=0 -> ACCESS;
  - otherwise -> WAIT with the wait counter loaded to WAIT_STATES-1.
- REQ-026 WAIT: hreadyout=0, hresp=0; the counter decrements each cycle; at counter=0 the next state is ACCESS.
- REQ-027 ACCESS: hreadyout=1, hresp=0; the FSM samples the next address phase exactly as IDLE does, so back-to-back transfers pipeline with no bubble.
- REQ-028 ERR1: hreadyout=0, hresp=1; next state ERR2 unconditionally.
- REQ-029 ERR2: hreadyout=1, hresp=1; the FSM samples the next address phase exactly as IDLE does.
- REQ-030 A write SHALL commit at the end of its ACCESS cycle, using hwdata sampled in that cycle.
- REQ-031 On a write, only byte lanes haddr[log2(DATA_WIDTH/8)-1:0] through that offset plus 2^hsize-1 are updated; all other bytes hold their value.
- REQ-032 wr_pulse[index] SHALL be 1 in the cycle after a write commits.
- REQ-033 A read SHALL drive hrdata in ACCESS with the full register word selected by the latched index (status_in for index 0). hrdata SHALL be 0 in every other state.
- REQ-034 An errored transfer SHALL modify no register and SHALL raise no wr_pulse.
- REQ-035 A read following a write to the same register SHALL return the newly written data.
- REQ-036 During WAIT or ERR1, address-phase inputs SHALL be ignored (hready is low on the bus).

Reset
- REQ-037 While hreset=1, asynchronously:
  - FSM = IDLE, wait counter = 0;
  - all registers = 0, wr_pulse = 0;
  - hrdata = 0, hreadyout = 1, hresp = 0.
- REQ-038 Reset asserted mid-transfer (WAIT, ACCESS or ERR state) SHALL abort the transfer and commit no write.
- REQ-039 The first valid address phase is accepted on the first rising edge after hreset deasserts.

Verification (DATA_WIDTH=32, NUM_REGS=8)
- REQ-040 With WAIT_STATES=0: word write 0xA5A5_1234 to haddr 0x08, followed back-to-back by a word read of 0x08:
  - hreadyout stays 1 throughout;
  - wr_pulse=0x04 for one cycle;
  - the read returns 0xA5A5_1234.
- REQ-041 Halfword write 0xBEEF to haddr 0x0E after register 3 = 0: reg 3 = 0xBEEF_0000.
- REQ-042 With WAIT_STATES=2: read of register 1 -> hreadyout is 0 for 2 cycles, then 1 with hrdata = register 1 contents.
- REQ-043 Error cases:
  - word write to haddr 0x02 (misaligned) -> ERR1 then ERR2 (hresp=1; hreadyout 0 then 1); no register changes; wr_pulse stays 0;
  - write to haddr 0x00 (register 0) -> same ERR1/ERR2 response, no register changes, wr_pulse stays 0;
  - hsize=3 -> same ERR1/ERR2 response, no register changes, wr_pulse stays 0.
- REQ-044 Read of haddr 0x00 with status_in = 0x0000_00C3 -> hrdata = 0x0000_00C3.
- REQ-045 hreset asserted during WAIT of a write -> immediate IDLE; all reg_q = 0; no wr_pulse.
